// File: rtl/mem_ctrl_if.sv
// Purpose: bundles the i_cache fetch, data-stage load/store and byte-wide RAM
//          signals shared between mem_ctrl and its requesters/RAM.
// Ports:   slave  = mem_ctrl view (requests and RAM read byte in, results and RAM bus out)
//          master = requester/RAM view (the mirror image)
interface mem_ctrl_if;
  // i_cache fetch side
  logic        inst_needed_i;
  logic [31:0] inst_addr_i;
  logic [31:0] inst_o;
  logic        inst_enable_o;
  // data-stage load/store side
  logic        data_req_i;
  logic        data_wr_i;
  logic [1:0]  data_len_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_w_i;
  logic [31:0] data_o;
  logic        data_enable_o;
  logic        mem_busy_o;
  // byte-serial RAM side
  logic [7:0]  mem_din_i;
  logic [7:0]  mem_dout_o;
  logic [31:0] mem_a_o;
  logic        mem_wr_o;

  modport slave (
    input  inst_needed_i, inst_addr_i,
    input  data_req_i, data_wr_i, data_len_i, data_addr_i, data_w_i,
    input  mem_din_i,
    output inst_o, inst_enable_o,
    output data_o, data_enable_o, mem_busy_o,
    output mem_dout_o, mem_a_o, mem_wr_o
  );

  modport master (
    output inst_needed_i, inst_addr_i,
    output data_req_i, data_wr_i, data_len_i, data_addr_i, data_w_i,
    output mem_din_i,
    input  inst_o, inst_enable_o,
    input  data_o, data_enable_o, mem_busy_o,
    input  mem_dout_o, mem_a_o, mem_wr_o
  );
endinterface

// File: rtl/mem_ctrl.sv
// Purpose: arbitrates i_cache fetches and data loads/stores onto a byte-serial RAM,
//          splitting accesses into 1/2/4 byte cycles and reassembling little-endian words.
// Latency: accept edge to done pulse = fetch 5, load len+1, store len cycles.
// Backpressure: mem_busy_o high from accept through the done-pulse cycle; requests are
//          levels sampled only in IDLE, data beats inst on a tie, inst waits without loss.
// Ports:   clk, rst (sync, active-high); bus = mem_ctrl_if.slave (fetch, load/store, RAM).
module mem_ctrl (
  input logic         clk,
  input logic         rst,
  mem_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;       // latched start address
  logic [2:0]  len_q, len_d;         // access length in bytes: 1, 2 or 4
  logic        src_inst_q, src_inst_d;
  logic [31:0] wdat_q, wdat_d;       // latched store data
  logic [2:0]  cnt_q, cnt_d;         // edges elapsed since accept, minus one
  logic [31:0] asm_q, asm_d;         // partially assembled read word

  logic [31:0] inst_q, inst_d;
  logic        inst_en_q, inst_en_d;
  logic [31:0] data_q, data_d;
  logic        data_en_q, data_en_d;
  logic        busy_q, busy_d;
  logic [7:0]  dout_q, dout_d;
  logic [31:0] a_q, a_d;
  logic        wr_q, wr_d;

  logic [2:0]  cnt_nxt;
  logic [1:0]  rd_idx;
  logic [31:0] rd_merged;
  logic [2:0]  req_len;

  assign cnt_nxt = cnt_q + 3'd1;
  // RAM read data lags its address by one cycle, so the byte arriving now
  // belongs to the address issued one edge earlier: index cnt-1.
  assign rd_idx    = cnt_q[1:0] - 2'd1;
  assign rd_merged = asm_q | (32'(bus.mem_din_i) << {rd_idx, 3'b000});
  // len code 2 is not a legal size; it is served as a full word.
  assign req_len   = (bus.data_len_i == 2'd0) ? 3'd1 :
                     (bus.data_len_i == 2'd1) ? 3'd2 : 3'd4;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    src_inst_d = src_inst_q;
    wdat_d     = wdat_q;
    cnt_d      = cnt_q;
    asm_d      = asm_q;
    inst_d     = inst_q;
    inst_en_d  = 1'b0;
    data_d     = data_q;
    data_en_d  = 1'b0;
    busy_d     = busy_q;
    dout_d     = dout_q;
    a_d        = a_q;
    wr_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.data_req_i) begin
          src_inst_d = 1'b0;
          addr_d     = bus.data_addr_i;
          len_d      = req_len;
          wdat_d     = bus.data_w_i;
          cnt_d      = 3'd0;
          asm_d      = 32'd0;
          busy_d     = 1'b1;
          a_d        = bus.data_addr_i;
          if (bus.data_wr_i) begin
            state_d = WR;
            wr_d    = 1'b1;
            dout_d  = bus.data_w_i[7:0];
          end else begin
            state_d = RD;
          end
        end else if (bus.inst_needed_i) begin
          src_inst_d = 1'b1;
          addr_d     = bus.inst_addr_i;
          len_d      = 3'd4;
          cnt_d      = 3'd0;
          asm_d      = 32'd0;
          busy_d     = 1'b1;
          a_d        = bus.inst_addr_i;
          state_d    = RD;
        end
      end

      RD: begin
        cnt_d = cnt_nxt;
        if (cnt_q == len_q) begin
          // final byte goes straight to the result register with the pulse
          if (src_inst_q) begin
            inst_d    = rd_merged;
            inst_en_d = 1'b1;
          end else begin
            data_d    = rd_merged;
            data_en_d = 1'b1;
          end
          state_d = DONE;
        end else begin
          if (cnt_q != 3'd0) begin
            asm_d = rd_merged;
          end
          if (cnt_nxt < len_q) begin
            a_d = addr_q + 32'(cnt_nxt);
          end
        end
      end

      WR: begin
        cnt_d = cnt_nxt;
        if (cnt_nxt == len_q) begin
          dout_d    = 8'd0;
          data_en_d = 1'b1;
          state_d   = DONE;
        end else begin
          wr_d   = 1'b1;
          a_d    = addr_q + 32'(cnt_nxt);
          dout_d = 8'(wdat_q >> {cnt_nxt[1:0], 3'b000});
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        a_d     = 32'd0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= 32'd0;
      len_q      <= 3'd0;
      src_inst_q <= 1'b0;
      wdat_q     <= 32'd0;
      cnt_q      <= 3'd0;
      asm_q      <= 32'd0;
      inst_q     <= 32'd0;
      inst_en_q  <= 1'b0;
      data_q     <= 32'd0;
      data_en_q  <= 1'b0;
      busy_q     <= 1'b0;
      dout_q     <= 8'd0;
      a_q        <= 32'd0;
      wr_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      src_inst_q <= src_inst_d;
      wdat_q     <= wdat_d;
      cnt_q      <= cnt_d;
      asm_q      <= asm_d;
      inst_q     <= inst_d;
      inst_en_q  <= inst_en_d;
      data_q     <= data_d;
      data_en_q  <= data_en_d;
      busy_q     <= busy_d;
      dout_q     <= dout_d;
      a_q        <= a_d;
      wr_q       <= wr_d;
    end
  end

  assign bus.inst_o        = inst_q;
  assign bus.inst_enable_o = inst_en_q;
  assign bus.data_o        = data_q;
  assign bus.data_enable_o = data_en_q;
  assign bus.mem_busy_o    = busy_q;
  assign bus.mem_dout_o    = dout_q;
  assign bus.mem_a_o       = a_q;
  assign bus.mem_wr_o      = wr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM model with 1-cycle read latency, i_cache and
// data-stage requesters, and a queue of expected results checked on completion.
module tb_mem_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_ctrl_if bus ();

  mem_ctrl u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0]  ram [logic [31:0]];
  logic [31:0] exp_q [$];

  // Initial RAM image: a few fixed bytes, a hashed pattern everywhere else.
  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    case (a)
      32'h0000_0100: return 8'hEF;
      32'h0000_0101: return 8'hBE;
      32'h0000_0102: return 8'hAD;
      32'h0000_0103: return 8'hDE;
      32'h0000_0203: return 8'h80;
      32'hFFFF_FFFF: return 8'h34;
      32'h0000_0000: return 8'h12;
      default:       return a[7:0] ^ a[15:8] ^ 8'hA5;
    endcase
  endfunction

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return {ram_rd(a + 32'd3), ram_rd(a + 32'd2), ram_rd(a + 32'd1), ram_rd(a)};
  endfunction

  always @(posedge clk) begin
    bus.mem_din_i <= ram_rd(bus.mem_a_o);
    if (bus.mem_wr_o) ram[bus.mem_a_o] = bus.mem_dout_o;
  end

  // Per-cycle trace of one transaction; index i is the i-th cycle after the accept edge.
  logic [31:0] tr_a    [0:63];
  logic        tr_wr   [0:63];
  logic        tr_busy [0:63];
  logic [7:0]  tr_dout [0:63];
  int          n_inst, n_data;
  logic [31:0] obs;
  logic [31:0] exp_v;

  // Waits (bounded) for the done pulse of the watched source; lat = -1 on timeout.
  task automatic run(input bit want_inst, input bit drop_data, input bit drop_inst, output int lat);
    lat    = -1;
    n_inst = 0;
    n_data = 0;
    obs    = 32'hx;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      tr_a[i]    = bus.mem_a_o;
      tr_wr[i]   = bus.mem_wr_o;
      tr_busy[i] = bus.mem_busy_o;
      tr_dout[i] = bus.mem_dout_o;
      if (i == 0) begin
        if (drop_data) begin
          bus.data_req_i  = 1'b0;
          bus.data_wr_i   = 1'b0;
          bus.data_addr_i = 32'hDEAD_0000;
          bus.data_w_i    = 32'hFFFF_FFFF;
        end
        if (drop_inst) begin
          bus.inst_needed_i = 1'b0;
          bus.inst_addr_i   = 32'hBAD0_0000;
        end
      end
      n_inst += int'(bus.inst_enable_o);
      n_data += int'(bus.data_enable_o);
      if (want_inst ? bus.inst_enable_o : bus.data_enable_o) begin
        lat = i;
        obs = want_inst ? bus.inst_o : bus.data_o;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.inst_needed_i = 1'b0;
    bus.inst_addr_i   = 32'd0;
    bus.data_req_i    = 1'b0;
    bus.data_wr_i     = 1'b0;
    bus.data_len_i    = 2'd0;
    bus.data_addr_i   = 32'd0;
    bus.data_w_i      = 32'd0;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.inst_o, bus.data_o, bus.mem_a_o, bus.mem_dout_o} !== 104'd0) begin
      bad++;
      $display("FAIL reset_words got=%h/%h/%h/%h want=0", bus.inst_o, bus.data_o, bus.mem_a_o, bus.mem_dout_o);
    end
    total++;
    if ({bus.inst_enable_o, bus.data_enable_o, bus.mem_busy_o, bus.mem_wr_o} !== 4'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b want=0000",
               {bus.inst_enable_o, bus.data_enable_o, bus.mem_busy_o, bus.mem_wr_o});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fetch();
    int  lat;
    logic any_wr;
    bus.inst_needed_i = 1'b1;
    bus.inst_addr_i   = 32'h100;
    exp_q.push_back(rd_word(32'h100));
    run(1'b1, 1'b0, 1'b1, lat);
    total++;
    if (lat !== 5) begin bad++; $display("FAIL fetch_latency got=%0d want=5", lat); end
    exp_v = exp_q.pop_front();
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL fetch_word got=%h want=%h", obs, exp_v); end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (tr_a[k] !== 32'h100 + k) begin
        bad++; $display("FAIL fetch_addr%0d got=%h want=%h", k, tr_a[k], 32'h100 + k);
      end
    end
    any_wr = 1'b0;
    for (int k = 0; k <= 5; k++) any_wr |= tr_wr[k];
    total++;
    if (any_wr !== 1'b0 || n_data !== 0) begin
      bad++; $display("FAIL fetch_no_write got=wr%b/dpulses%0d want=0/0", any_wr, n_data);
    end
    total++;
    if (tr_busy[5] !== 1'b1) begin bad++; $display("FAIL fetch_busy_in_pulse got=%b want=1", tr_busy[5]); end
    @(negedge clk);
    total++;
    if ({bus.inst_enable_o, bus.mem_busy_o} !== 2'b00 || bus.mem_a_o !== 32'd0) begin
      bad++; $display("FAIL fetch_after_pulse got=en%b busy%b a=%h want=0/0/0",
                      bus.inst_enable_o, bus.mem_busy_o, bus.mem_a_o);
    end
    total++;
    if (bus.inst_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL fetch_hold got=%h want=deadbeef", bus.inst_o); end
  endtask

  task automatic test_arbitration();
    int lat;
    bus.inst_needed_i = 1'b1;
    bus.inst_addr_i   = 32'h100;
    bus.data_req_i    = 1'b1;
    bus.data_wr_i     = 1'b0;
    bus.data_len_i    = 2'd0;
    bus.data_addr_i   = 32'h203;
    exp_q.push_back({24'd0, ram_rd(32'h203)});
    run(1'b0, 1'b1, 1'b0, lat);
    total++;
    if (lat !== 2) begin bad++; $display("FAIL arb_load_latency got=%0d want=2", lat); end
    exp_v = exp_q.pop_front();
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL arb_load_data got=%h want=%h", obs, exp_v); end
    total++;
    if (n_inst !== 0) begin bad++; $display("FAIL arb_early_inst got=%0d want=0", n_inst); end
    @(negedge clk);
    total++;
    if (bus.mem_busy_o !== 1'b0 || bus.inst_enable_o !== 1'b0) begin
      bad++; $display("FAIL arb_gap got=busy%b en%b want=0/0", bus.mem_busy_o, bus.inst_enable_o);
    end
    exp_q.push_back(rd_word(32'h100));
    run(1'b1, 1'b0, 1'b1, lat);
    total++;
    if (lat !== 5) begin bad++; $display("FAIL arb_fetch_latency got=%0d want=5", lat); end
    exp_v = exp_q.pop_front();
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL arb_fetch_word got=%h want=%h", obs, exp_v); end
    @(negedge clk);
  endtask

  task automatic test_store();
    int lat;
    logic [31:0] w;
    w = 32'h1122_3344;
    bus.data_req_i  = 1'b1;
    bus.data_wr_i   = 1'b1;
    bus.data_len_i  = 2'd3;
    bus.data_addr_i = 32'h200;
    bus.data_w_i    = w;
    exp_q.push_back(w);
    run(1'b0, 1'b1, 1'b0, lat);
    total++;
    if (lat !== 4) begin bad++; $display("FAIL store_latency got=%0d want=4", lat); end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (tr_wr[k] !== 1'b1 || tr_a[k] !== 32'h200 + k || tr_dout[k] !== w[8*k +: 8]) begin
        bad++; $display("FAIL store_cycle%0d got=wr%b a=%h d=%h want=1/%h/%h",
                        k, tr_wr[k], tr_a[k], tr_dout[k], 32'h200 + k, w[8*k +: 8]);
      end
    end
    total++;
    if (tr_wr[4] !== 1'b0) begin bad++; $display("FAIL store_wr_drop got=%b want=0", tr_wr[4]); end
    @(negedge clk);
    exp_v = exp_q.pop_front();
    total++;
    if (rd_word(32'h200) !== exp_v) begin
      bad++; $display("FAIL store_ram got=%h want=%h", rd_word(32'h200), exp_v);
    end
  endtask

  task automatic test_wrap();
    int lat;
    bus.data_req_i  = 1'b1;
    bus.data_wr_i   = 1'b0;
    bus.data_len_i  = 2'd1;
    bus.data_addr_i = 32'hFFFF_FFFF;
    exp_q.push_back({16'd0, ram_rd(32'h0), ram_rd(32'hFFFF_FFFF)});
    run(1'b0, 1'b1, 1'b0, lat);
    total++;
    if (lat !== 3) begin bad++; $display("FAIL wrap_latency got=%0d want=3", lat); end
    total++;
    if (tr_a[0] !== 32'hFFFF_FFFF || tr_a[1] !== 32'h0) begin
      bad++; $display("FAIL wrap_addr got=%h,%h want=ffffffff,00000000", tr_a[0], tr_a[1]);
    end
    exp_v = exp_q.pop_front();
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL wrap_data got=%h want=%h", obs, exp_v); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [7:0] old2, old3;
    int pulses;
    old2 = ram_rd(32'h302);
    old3 = ram_rd(32'h303);
    bus.data_req_i  = 1'b1;
    bus.data_wr_i   = 1'b1;
    bus.data_len_i  = 2'd3;
    bus.data_addr_i = 32'h300;
    bus.data_w_i    = 32'h5566_7788;
    @(negedge clk);                 // cycle 1
    bus.data_req_i = 1'b0;
    @(negedge clk);                 // cycle 2
    rst = 1'b1;
    @(negedge clk);                 // cycle 3
    total++;
    if ({bus.mem_wr_o, bus.mem_busy_o} !== 2'b00 || bus.mem_a_o !== 32'd0) begin
      bad++; $display("FAIL rstmid_outputs got=wr%b busy%b a=%h want=0/0/0",
                      bus.mem_wr_o, bus.mem_busy_o, bus.mem_a_o);
    end
    rst = 1'b0;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      pulses += int'(bus.data_enable_o) + int'(bus.inst_enable_o);
    end
    total++;
    if (pulses !== 0) begin bad++; $display("FAIL rstmid_pulse got=%0d want=0", pulses); end
    total++;
    if (ram_rd(32'h302) !== old2 || ram_rd(32'h303) !== old3) begin
      bad++; $display("FAIL rstmid_ram got=%h%h want=%h%h", ram_rd(32'h303), ram_rd(32'h302), old3, old2);
    end
    total++;
    if (ram_rd(32'h300) !== 8'h88 || ram_rd(32'h301) !== 8'h77) begin
      bad++; $display("FAIL rstmid_first_bytes got=%h%h want=7788", ram_rd(32'h301), ram_rd(32'h300));
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic all_busy;
    bus.inst_needed_i = 1'b1;
    bus.inst_addr_i   = 32'h400;
    exp_q.push_back(rd_word(32'h400));
    for (int m = 0; m < 3; m++) begin
      run(1'b1, 1'b0, 1'b0, lat);
      total++;
      if (lat !== 5) begin bad++; $display("FAIL b2b_latency%0d got=%0d want=5", m, lat); end
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL b2b_word%0d got=%h want=%h", m, obs, exp_v); end
      all_busy = 1'b1;
      for (int k = 0; k <= 5; k++) all_busy &= tr_busy[k];
      total++;
      if (all_busy !== 1'b1) begin bad++; $display("FAIL b2b_busy%0d got=%b want=1", m, all_busy); end
      // i_cache presents the next miss while the current one completes
      if (m < 2) begin
        bus.inst_addr_i = 32'h404 + 32'(4 * m);
        exp_q.push_back(rd_word(32'h404 + 32'(4 * m)));
      end else begin
        bus.inst_needed_i = 1'b0;
      end
      @(negedge clk);
      total++;
      if (bus.mem_busy_o !== 1'b0) begin bad++; $display("FAIL b2b_gap%0d got=%b want=0", m, bus.mem_busy_o); end
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_arbitration();
    test_store();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
